// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement buffer that returns old physical registers to the free list.
// Define ROB_ERR_EN to build the sticky rob_err protocol check; otherwise rob_err is tied low.
module reorder_buffer #(
    parameter int DEPTH  = 16,
    parameter int PHYS_W = 6,
    parameter int ARCH_W = 5,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              alloc_valid,
    input  logic              alloc_has_rd,
    input  logic [ARCH_W-1:0] alloc_arch_rd,
    input  logic [PHYS_W-1:0] alloc_phys_rd,
    input  logic [PHYS_W-1:0] alloc_old_phys_rd,
    output logic              alloc_ready,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              complete_valid,
    input  logic [TAG_W-1:0]  complete_tag,
    output logic              retire_valid,
    output logic [PHYS_W-1:0] retire_phys_reg,
    output logic [ARCH_W-1:0] retire_arch_rd,
    output logic              retire_event,
    output logic              rob_empty,
    output logic              rob_full,
    output logic [TAG_W:0]    rob_count,
    output logic              rob_err
);
    logic [TAG_W:0]      head, tail;
    logic [DEPTH-1:0]    valid, done, has_rd;
    logic [ARCH_W-1:0]   arch_rd [DEPTH];
    logic [PHYS_W-1:0]   old_phys [DEPTH];
    logic [TAG_W-1:0]    hidx, tidx;
    logic                full, do_alloc, do_comp, do_retire;
    logic                unused_phys;

    // The new mapping is only needed by rename; retirement frees the old one.
    assign unused_phys = ^alloc_phys_rd;
    assign hidx        = head[TAG_W-1:0];
    assign tidx        = tail[TAG_W-1:0];
    assign full        = (hidx == tidx) && (head[TAG_W] != tail[TAG_W]);
    assign rob_full    = full;
    assign rob_empty   = head == tail;
    assign rob_count   = tail - head;
    assign alloc_ready = !full;
    assign alloc_tag   = tidx;
    assign do_alloc    = alloc_valid && !full;
    assign do_comp     = complete_valid && valid[complete_tag];
    assign do_retire   = valid[hidx] && done[hidx];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head            <= '0;
            tail            <= '0;
            valid           <= '0;
            done            <= '0;
            retire_valid    <= 1'b0;
            retire_event    <= 1'b0;
            retire_phys_reg <= '0;
            retire_arch_rd  <= '0;
        end else begin
            if (do_comp) done[complete_tag] <= 1'b1;
            // Retire clears after completion so a late completion to the head cannot leave done set.
            if (do_retire) begin
                valid[hidx]     <= 1'b0;
                done[hidx]      <= 1'b0;
                head            <= head + 1'b1;
                retire_phys_reg <= old_phys[hidx];
                retire_arch_rd  <= arch_rd[hidx];
            end
            if (do_alloc) begin
                valid[tidx] <= 1'b1;
                done[tidx]  <= 1'b0;
                tail        <= tail + 1'b1;
            end
            retire_valid <= do_retire && has_rd[hidx];
            retire_event <= do_retire;
        end
    end

    always_ff @(posedge clk) begin
        if (do_alloc) begin
            has_rd[tidx]   <= alloc_has_rd;
            arch_rd[tidx]  <= alloc_arch_rd;
            old_phys[tidx] <= alloc_old_phys_rd;
        end
    end

`ifdef ROB_ERR_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            rob_err <= 1'b0;
        else if ((alloc_valid && full) ||
                 (complete_valid && !(valid[complete_tag] && !done[complete_tag])))
            rob_err <= 1'b1;
    end
`else
    assign rob_err = 1'b0;
`endif
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: scenario tasks plus a retirement scoreboard fed in allocation order.
module tb_reorder_buffer;
    typedef struct packed {
        logic       hr;
        logic [4:0] arch;
        logic [5:0] phys;
    } ent_t;

`ifdef ROB_ERR_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       alloc_valid = 1'b0, alloc_has_rd = 1'b0;
    logic [4:0] alloc_arch_rd = '0;
    logic [5:0] alloc_phys_rd = '0, alloc_old_phys_rd = '0;
    logic       alloc_ready;
    logic [3:0] alloc_tag;
    logic       complete_valid = 1'b0;
    logic [3:0] complete_tag = '0;
    logic       retire_valid, retire_event, rob_empty, rob_full, rob_err;
    logic [5:0] retire_phys_reg;
    logic [4:0] retire_arch_rd;
    logic [4:0] rob_count;

    int   total = 0, bad = 0;
    int   mt = 0;
    ent_t q[$];

    reorder_buffer dut (
        .clk(clk), .reset_n(reset_n),
        .alloc_valid(alloc_valid), .alloc_has_rd(alloc_has_rd), .alloc_arch_rd(alloc_arch_rd),
        .alloc_phys_rd(alloc_phys_rd), .alloc_old_phys_rd(alloc_old_phys_rd),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .complete_valid(complete_valid), .complete_tag(complete_tag),
        .retire_valid(retire_valid), .retire_phys_reg(retire_phys_reg),
        .retire_arch_rd(retire_arch_rd), .retire_event(retire_event),
        .rob_empty(rob_empty), .rob_full(rob_full), .rob_count(rob_count), .rob_err(rob_err)
    );

    always #5 clk = ~clk;

    // Every retirement must match the oldest outstanding allocation.
    always @(posedge clk) begin
        #1;
        if (retire_event === 1'b1) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL retire_unexpected: got phys=%0d with no entry outstanding", retire_phys_reg);
            end else begin
                ent_t e;
                e = q.pop_front();
                if ({retire_valid, retire_arch_rd, retire_phys_reg} !== e) begin
                    bad++;
                    $display("FAIL retire_order: got hr=%b arch=%0d phys=%0d want hr=%b arch=%0d phys=%0d",
                             retire_valid, retire_arch_rd, retire_phys_reg, e.hr, e.arch, e.phys);
                end
            end
        end else if (retire_valid !== 1'b0) begin
            total++;
            bad++;
            $display("FAIL retire_valid_alone: got %b want 0", retire_valid);
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_alloc(input logic hr, input logic [4:0] arch, input logic [5:0] old);
        alloc_valid       = 1'b1;
        alloc_has_rd      = hr;
        alloc_arch_rd     = arch;
        alloc_phys_rd     = old + 6'd32;
        alloc_old_phys_rd = old;
        q.push_back('{hr, arch, old});
        mt = (mt + 1) % 16;
        step();
        alloc_valid = 1'b0;
    endtask

    task automatic check_reset_state(input string nm);
        total++;
        if ({rob_count, rob_empty, rob_full, alloc_ready, alloc_tag} !== {5'd0, 1'b1, 1'b0, 1'b1, 4'd0}) begin
            bad++;
            $display("FAIL %s_ptrs: got count=%0d empty=%b full=%b ready=%b tag=%0d want 0 1 0 1 0",
                     nm, rob_count, rob_empty, rob_full, alloc_ready, alloc_tag);
        end
        total++;
        if ({retire_valid, retire_event, retire_phys_reg, retire_arch_rd, rob_err} !== 14'd0) begin
            bad++;
            $display("FAIL %s_outs: got rv=%b re=%b phys=%0d arch=%0d err=%b want all 0",
                     nm, retire_valid, retire_event, retire_phys_reg, retire_arch_rd, rob_err);
        end
    endtask

    task automatic test_reset;
        #2;
        check_reset_state("reset");
        repeat (2) step();
        reset_n = 1'b1;
        step();
        check_reset_state("after_release");
    endtask

    task automatic test_in_order;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (alloc_tag !== 4'(i)) begin
                bad++;
                $display("FAIL order_tag: got %0d want %0d", alloc_tag, i);
            end
            do_alloc(1'b1, 5'(i + 1), 6'(5 + i));
        end
        total++;
        if (rob_count !== 5'd3) begin
            bad++;
            $display("FAIL order_count: got %0d want 3", rob_count);
        end
        complete_valid = 1'b1;
        complete_tag = 4'd2; step();
        complete_tag = 4'd1; step();
        complete_tag = 4'd0; step();
        complete_valid = 1'b0;
        total++;
        if (retire_event !== 1'b0) begin
            bad++;
            $display("FAIL order_early: got retire_event=%b want 0", retire_event);
        end
        step();
        total++;
        if ({retire_valid, retire_phys_reg} !== {1'b1, 6'd5}) begin
            bad++;
            $display("FAIL order_first: got rv=%b phys=%0d want 1 5", retire_valid, retire_phys_reg);
        end
        repeat (3) step();
        total++;
        if ({rob_empty, rob_count} !== {1'b1, 5'd0}) begin
            bad++;
            $display("FAIL order_drain: got empty=%b count=%0d want 1 0", rob_empty, rob_count);
        end
    endtask

    task automatic test_fill;
        int base;
        base = mt;
        for (int i = 0; i < 16; i++) do_alloc(1'b1, 5'(i), 6'(i + 10));
        total++;
        if ({rob_full, alloc_ready, rob_count} !== {1'b1, 1'b0, 5'd16}) begin
            bad++;
            $display("FAIL fill_full: got full=%b ready=%b count=%0d want 1 0 16", rob_full, alloc_ready, rob_count);
        end
        alloc_valid = 1'b1; alloc_has_rd = 1'b1; alloc_arch_rd = 5'd31; alloc_old_phys_rd = 6'd63;
        step();
        alloc_valid = 1'b0;
        total++;
        if ({rob_count, rob_err} !== {5'd16, ERR}) begin
            bad++;
            $display("FAIL fill_drop: got count=%0d err=%b want 16 %b", rob_count, rob_err, ERR);
        end
        complete_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            complete_tag = 4'((base + i) % 16);
            step();
        end
        complete_valid = 1'b0;
        repeat (2) step();
        total++;
        if ({rob_empty, rob_count} !== {1'b1, 5'd0}) begin
            bad++;
            $display("FAIL fill_drain: got empty=%b count=%0d want 1 0", rob_empty, rob_count);
        end
    endtask

    task automatic test_no_rd;
        int t;
        t = mt;
        do_alloc(1'b0, 5'd7, 6'd33);
        complete_valid = 1'b1; complete_tag = 4'(t);
        step();
        complete_valid = 1'b0;
        step();
        total++;
        if ({retire_event, retire_valid, retire_phys_reg, rob_count} !== {1'b1, 1'b0, 6'd33, 5'd0}) begin
            bad++;
            $display("FAIL no_rd: got re=%b rv=%b phys=%0d count=%0d want 1 0 33 0",
                     retire_event, retire_valid, retire_phys_reg, rob_count);
        end
        step();
    endtask

    task automatic test_wrap;
        int tg[40];
        for (int c = 0; c < 40; c++) begin
            tg[c] = mt;
            total++;
            if (alloc_tag !== 4'(mt)) begin
                bad++;
                $display("FAIL wrap_tag: got %0d want %0d", alloc_tag, mt);
            end
            complete_valid = c >= 2;
            complete_tag = (c >= 2) ? 4'(tg[c-2]) : 4'd0;
            do_alloc(c[0], 5'(c % 32), 6'(c));
            complete_valid = 1'b0;
            if (c >= 2) begin
                total++;
                if (rob_count !== 5'd3) begin
                    bad++;
                    $display("FAIL wrap_count: cycle %0d got %0d want 3", c, rob_count);
                end
            end
        end
        complete_valid = 1'b1;
        complete_tag = 4'(tg[38]); step();
        complete_tag = 4'(tg[39]); step();
        complete_valid = 1'b0;
        repeat (3) step();
        total++;
        if ({rob_empty, rob_count} !== {1'b1, 5'd0}) begin
            bad++;
            $display("FAIL wrap_drain: got empty=%b count=%0d want 1 0", rob_empty, rob_count);
        end
    endtask

    task automatic test_invalid_complete;
        complete_valid = 1'b1; complete_tag = 4'd9;
        step();
        complete_valid = 1'b0;
        step();
        total++;
        if ({rob_empty, rob_count, retire_event, rob_err} !== {1'b1, 5'd0, 1'b0, ERR}) begin
            bad++;
            $display("FAIL invalid_complete: got empty=%b count=%0d re=%b err=%b want 1 0 0 %b",
                     rob_empty, rob_count, retire_event, rob_err, ERR);
        end
    endtask

    task automatic test_reset_mid;
        int last;
        for (int i = 0; i < 5; i++) begin
            last = mt;
            do_alloc(1'b1, 5'(20 + i), 6'(40 + i));
        end
        complete_valid = 1'b1; complete_tag = 4'(last);
        step();
        complete_valid = 1'b0;
        total++;
        if (rob_count !== 5'd5) begin
            bad++;
            $display("FAIL mid_count: got %0d want 5", rob_count);
        end
        #2;
        reset_n = 1'b0;
        q.delete();
        mt = 0;
        #1;
        check_reset_state("mid_reset");
        step();
        reset_n = 1'b1;
        repeat (4) begin
            step();
            total++;
            if ({retire_event, rob_count} !== 6'd0) begin
                bad++;
                $display("FAIL mid_after: got re=%b count=%0d want 0 0", retire_event, rob_count);
            end
        end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_fill();
        test_no_rd();
        test_wrap();
        test_invalid_complete();
        test_reset_mid();
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL leftover: got %0d unretired entries want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
